// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the EX-stage operand forwarding controller:
// operand mux select codes and tracking-slot field widths.
package fwd_hazard_ctrl_pkg;

    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_RF   = 3'b000;
    localparam logic [SEL_W-1:0] SEL_MEM  = 3'b001;
    localparam logic [SEL_W-1:0] SEL_WB   = 3'b010;
    localparam logic [SEL_W-1:0] SEL_RET  = 3'b011;
    localparam logic [SEL_W-1:0] SEL_IMM  = 3'b100;
    localparam logic [SEL_W-1:0] SEL_PC   = 3'b101;
    localparam logic [SEL_W-1:0] SEL_FOUR = 3'b110;
    localparam logic [SEL_W-1:0] SEL_ZERO = 3'b111;

    localparam int SLOT_RA_W   = 5;
    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_match.sv
// Compares one source register against the in-flight ex/mem/wb destinations
// and returns the forwarding select of the nearest producer.
module fwd_match
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int RA_W = SLOT_RA_W
) (
    input  logic             src_used,
    input  logic [RA_W-1:0]  src,
    input  logic             ex_v,
    input  logic             ex_wen,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic             mem_v,
    input  logic             mem_wen,
    input  logic [RA_W-1:0]  mem_rd,
    input  logic             wb_v,
    input  logic             wb_wen,
    input  logic [RA_W-1:0]  wb_rd,
    output logic [SEL_W-1:0] sel
);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    // x0 is hard-wired zero, so a write to it never produces a forward
    assign ex_hit  = src_used & ex_v  & ex_wen  & (ex_rd  != '0) & (src == ex_rd);
    assign mem_hit = src_used & mem_v & mem_wen & (mem_rd != '0) & (src == mem_rd);
    assign wb_hit  = src_used & wb_v  & wb_wen  & (wb_rd  != '0) & (src == wb_rd);

    always_comb begin
        sel = SEL_RF;
        if (ex_hit) begin
            sel = SEL_MEM;
        end else if (mem_hit) begin
            sel = SEL_WB;
        end else if (wb_hit) begin
            sel = SEL_RET;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding/hazard sequencer for the RV32I EX operand muxes: tracks in-flight
// destinations, registers the A/B selects, and inserts load-use stalls.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int RA_W  = SLOT_RA_W,
    parameter int CNT_W = STALL_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_a_pc,
    input  logic             id_b_imm,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_wen,
    input  logic             id_load,
    input  logic             flush,
    input  logic             hold,
    output logic [SEL_W-1:0] sel_a,
    output logic [SEL_W-1:0] sel_b,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    // Tracking slots: _p0 = ex, _p1 = mem, _p2 = wb. The ret slot needs no
    // storage: its producer is only ever consumed as the wb match (code 011).
    logic            vld_p0, vld_p1, vld_p2;
    logic            wen_p0, wen_p1, wen_p2;
    logic [RA_W-1:0] rd_p0, rd_p1, rd_p2;
    logic            load_p0;

    logic [SEL_W-1:0] fwd_a, fwd_b;
    logic [SEL_W-1:0] sel_a_nxt, sel_b_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             ld_hit_rs1, ld_hit_rs2;
    logic             bubble;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    fwd_match #(.RA_W(RA_W)) u_match_rs1 (
        .src_used (id_use_rs1),
        .src      (id_rs1),
        .ex_v     (vld_p0),
        .ex_wen   (wen_p0),
        .ex_rd    (rd_p0),
        .mem_v    (vld_p1),
        .mem_wen  (wen_p1),
        .mem_rd   (rd_p1),
        .wb_v     (vld_p2),
        .wb_wen   (wen_p2),
        .wb_rd    (rd_p2),
        .sel      (fwd_a)
    );

    fwd_match #(.RA_W(RA_W)) u_match_rs2 (
        .src_used (id_use_rs2),
        .src      (id_rs2),
        .ex_v     (vld_p0),
        .ex_wen   (wen_p0),
        .ex_rd    (rd_p0),
        .mem_v    (vld_p1),
        .mem_wen  (wen_p1),
        .mem_rd   (rd_p1),
        .wb_v     (vld_p2),
        .wb_wen   (wen_p2),
        .wb_rd    (rd_p2),
        .sel      (fwd_b)
    );

    // Load data is not ready until the end of MEM, so a consumer directly
    // behind a load must wait one cycle.
    assign ld_hit_rs1 = id_use_rs1 & (id_rs1 == rd_p0);
    assign ld_hit_rs2 = id_use_rs2 & (id_rs2 == rd_p0);
    assign stall      = id_valid & vld_p0 & load_p0 & wen_p0 & (rd_p0 != '0)
                      & (ld_hit_rs1 | ld_hit_rs2);
    assign bubble     = flush | stall;

    always_comb begin
        sel_a_nxt = SEL_ZERO;
        sel_b_nxt = SEL_ZERO;
        if (!bubble && id_valid) begin
            sel_a_nxt = id_a_pc  ? SEL_PC  : fwd_a;
            sel_b_nxt = id_b_imm ? SEL_IMM : fwd_b;
        end
    end

    // ID -> EX boundary: slot valids, selects and stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            sel_a  <= SEL_RF;
            sel_b  <= SEL_RF;
            cnt_q  <= '0;
        end else if (!hold) begin
            vld_p0 <= id_valid & ~bubble;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            sel_a  <= sel_a_nxt;
            sel_b  <= sel_b_nxt;
            if (stall && !flush) begin
                cnt_q <= sat_inc(cnt_q);
            end
        end
    end

    // Slot payload is qualified by the valids above, so it carries no reset
    always_ff @(posedge clk) begin
        if (!hold) begin
            rd_p0   <= id_rd;
            wen_p0  <= id_wen;
            load_p0 <= id_load;
            rd_p1   <= rd_p0;
            wen_p1  <= wen_p0;
            rd_p2   <= rd_p1;
            wen_p2  <= wen_p1;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed pipeline scenarios plus
// randomized traffic against an instruction-history reference model.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, id_use_rs1, id_use_rs2, id_a_pc, id_b_imm;
    logic       id_wen, id_load, flush, hold;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic [2:0]  sel_a, sel_b, sel_a_s, sel_b_s;
    logic        stall, stall_s;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt_s;

    fwd_hazard_ctrl #(.RA_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_a_pc(id_a_pc),
        .id_b_imm(id_b_imm), .id_rd(id_rd), .id_wen(id_wen), .id_load(id_load),
        .flush(flush), .hold(hold), .sel_a(sel_a), .sel_b(sel_b), .stall(stall),
        .stall_cnt(stall_cnt)
    );

    // Narrow-counter instance so saturation is reachable in a short run
    fwd_hazard_ctrl #(.RA_W(5), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_a_pc(id_a_pc),
        .id_b_imm(id_b_imm), .id_rd(id_rd), .id_wen(id_wen), .id_load(id_load),
        .flush(flush), .hold(hold), .sel_a(sel_a_s), .sel_b(sel_b_s), .stall(stall_s),
        .stall_cnt(stall_cnt_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int rd;
        bit wen;
        bit load;
    } ent_t;

    // hist[0] is the instruction currently in EX, hist[k] entered EX k edges earlier
    ent_t       hist[$];
    int         exp_cnt;
    logic [2:0] exp_sel_a, exp_sel_b;
    bit         exp_stall;
    logic       obs_stall, obs_stall_s;
    int         errors = 0;
    int         checks = 0;
    int         base;

    function automatic int sat(int c, int w);
        int m;
        m = (1 << w) - 1;
        return (c > m) ? m : c;
    endfunction

    function automatic bit m_stall();
        ent_t e;
        e = hist[0];
        if (!id_valid || !e.v || !e.load || !e.wen || e.rd == 0) return 1'b0;
        return (id_use_rs1 && int'(id_rs1) == e.rd) || (id_use_rs2 && int'(id_rs2) == e.rd);
    endfunction

    function automatic logic [2:0] m_src(bit used, int rs);
        if (!used) return 3'b000;
        for (int d = 0; d < 3; d++) begin
            if (hist[d].v && hist[d].wen && hist[d].rd != 0 && hist[d].rd == rs)
                return 3'(d + 1);
        end
        return 3'b000;
    endfunction

    task automatic m_reset();
        ent_t b;
        b = '{v: 1'b0, rd: 0, wen: 1'b0, load: 1'b0};
        hist.delete();
        repeat (4) hist.push_back(b);
        exp_sel_a = 3'b000;
        exp_sel_b = 3'b000;
        exp_cnt   = 0;
    endtask

    task automatic m_advance();
        ent_t e;
        bit   s;
        if (hold) return;
        s = m_stall();
        e = '{v: 1'b0, rd: 0, wen: 1'b0, load: 1'b0};
        if (flush || s || !id_valid) begin
            exp_sel_a = 3'b111;
            exp_sel_b = 3'b111;
        end else begin
            exp_sel_a = id_a_pc  ? 3'b101 : m_src(id_use_rs1, int'(id_rs1));
            exp_sel_b = id_b_imm ? 3'b100 : m_src(id_use_rs2, int'(id_rs2));
        end
        if (!flush && !s) e = '{v: id_valid, rd: int'(id_rd), wen: id_wen, load: id_load};
        hist.push_front(e);
        void'(hist.pop_back());
        if (s && !flush) exp_cnt++;
    endtask

    task automatic set_id(bit v, int rs1, int rs2, bit u1, bit u2, bit apc, bit bimm,
                          int rd, bit wen, bit load);
        id_valid = v;   id_rs1 = 5'(rs1);  id_rs2 = 5'(rs2);
        id_use_rs1 = u1; id_use_rs2 = u2;  id_a_pc = apc; id_b_imm = bimm;
        id_rd = 5'(rd); id_wen = wen;      id_load = load;
    endtask

    task automatic op_alu(int rd, int rs1, bit u1, int rs2, bit u2);
        set_id(1'b1, rs1, rs2, u1, u2, 1'b0, 1'b0, rd, 1'b1, 1'b0);
    endtask

    task automatic op_load(int rd, int rs1);
        set_id(1'b1, rs1, 0, 1'b1, 1'b0, 1'b0, 1'b1, rd, 1'b1, 1'b1);
    endtask

    task automatic op_idle();
        set_id(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // One clock: capture combinational stall mid-cycle, then advance the model
    task automatic tick();
        @(negedge clk);
        obs_stall   = stall;
        obs_stall_s = stall_s;
        exp_stall   = m_stall();
        @(posedge clk);
        m_advance();
        #1;
    endtask

    task automatic idle_cycles(int n);
        op_idle();
        flush = 1'b0;
        hold  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        op_idle();
        flush = 1'b0;
        hold  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (sel_a !== 3'b000) begin errors++; $display("FAIL reset sel_a: got %b want 000", sel_a); end
        checks++; if (sel_b !== 3'b000) begin errors++; $display("FAIL reset sel_b: got %b want 000", sel_b); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset stall: got %b want 0", stall); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset stall_cnt: got %0d want 0", stall_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic test_ex_forward();
        idle_cycles(4);
        op_alu(5, 0, 1'b0, 0, 1'b0);
        tick();
        op_alu(6, 5, 1'b1, 1, 1'b1);
        tick();
        checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL exfwd stall: got %b want 0", obs_stall); end
        checks++; if (sel_a !== 3'b001) begin errors++; $display("FAIL exfwd sel_a: got %b want 001", sel_a); end
        checks++; if (sel_b !== 3'b000) begin errors++; $display("FAIL exfwd sel_b: got %b want 000", sel_b); end
    endtask

    task automatic test_load_use();
        idle_cycles(4);
        op_load(7, 2);
        tick();
        checks++; if (sel_b !== 3'b100) begin errors++; $display("FAIL load sel_b: got %b want 100", sel_b); end
        op_alu(8, 7, 1'b1, 7, 1'b1);
        base = exp_cnt;
        tick();
        checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL ldu stall: got %b want 1", obs_stall); end
        checks++; if (sel_a !== 3'b111 || sel_b !== 3'b111) begin errors++; $display("FAIL ldu bubble sel: got %b/%b want 111/111", sel_a, sel_b); end
        checks++; if (stall_cnt !== 16'(base + 1)) begin errors++; $display("FAIL ldu stall_cnt: got %0d want %0d", stall_cnt, base + 1); end
        tick();
        checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL ldu stall2: got %b want 0", obs_stall); end
        checks++; if (sel_a !== 3'b010 || sel_b !== 3'b010) begin errors++; $display("FAIL ldu consumer sel: got %b/%b want 010/010", sel_a, sel_b); end
        checks++; if (stall_cnt !== 16'(base + 1)) begin errors++; $display("FAIL ldu cnt hold: got %0d want %0d", stall_cnt, base + 1); end
    endtask

    task automatic test_x0_and_distance();
        idle_cycles(4);
        op_alu(0, 3, 1'b1, 4, 1'b1);
        tick();
        op_alu(10, 0, 1'b1, 0, 1'b1);
        tick();
        checks++; if (sel_a !== 3'b000 || sel_b !== 3'b000) begin errors++; $display("FAIL x0 sel: got %b/%b want 000/000", sel_a, sel_b); end
        op_alu(9, 0, 1'b0, 0, 1'b0);
        tick();
        op_alu(0, 0, 1'b0, 0, 1'b0);
        repeat (2) tick();
        op_alu(11, 9, 1'b1, 0, 1'b0);
        tick();
        checks++; if (sel_a !== 3'b011) begin errors++; $display("FAIL dist3 sel_a: got %b want 011", sel_a); end
        checks++; if (sel_b !== 3'b000) begin errors++; $display("FAIL dist3 sel_b: got %b want 000", sel_b); end
        op_alu(9, 0, 1'b0, 0, 1'b0);
        tick();
        op_alu(0, 0, 1'b0, 0, 1'b0);
        tick();
        op_alu(9, 0, 1'b0, 0, 1'b0);
        tick();
        op_alu(12, 3, 1'b0, 9, 1'b1);
        tick();
        checks++; if (sel_b !== 3'b001 || sel_a !== 3'b000) begin errors++; $display("FAIL nearest sel: got %b/%b want 000/001", sel_a, sel_b); end
        set_id(1'b1, 9, 9, 1'b1, 1'b1, 1'b1, 1'b1, 13, 1'b1, 1'b0);
        tick();
        checks++; if (sel_a !== 3'b101 || sel_b !== 3'b100) begin errors++; $display("FAIL override sel: got %b/%b want 101/100", sel_a, sel_b); end
        op_idle();
        tick();
        checks++; if (sel_a !== 3'b111 || sel_b !== 3'b111) begin errors++; $display("FAIL invalid sel: got %b/%b want 111/111", sel_a, sel_b); end
    endtask

    task automatic test_flush();
        idle_cycles(4);
        op_load(7, 2);
        tick();
        op_alu(8, 7, 1'b1, 7, 1'b1);
        flush = 1'b1;
        base  = exp_cnt;
        tick();
        flush = 1'b0;
        checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL flush raw stall: got %b want 1", obs_stall); end
        checks++; if (sel_a !== 3'b111 || sel_b !== 3'b111) begin errors++; $display("FAIL flush sel: got %b/%b want 111/111", sel_a, sel_b); end
        checks++; if (stall_cnt !== 16'(base)) begin errors++; $display("FAIL flush cnt: got %0d want %0d", stall_cnt, base); end
        tick();
        checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL post-flush stall: got %b want 0", obs_stall); end
        checks++; if (sel_a !== 3'b010 || sel_b !== 3'b010) begin errors++; $display("FAIL post-flush sel: got %b/%b want 010/010", sel_a, sel_b); end
    endtask

    task automatic test_hold();
        idle_cycles(4);
        set_id(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 5, 1'b1, 1'b0);
        tick();
        op_alu(6, 5, 1'b1, 1, 1'b1);
        hold = 1'b1;
        repeat (3) begin
            tick();
            checks++; if (sel_a !== 3'b101 || sel_b !== 3'b000) begin errors++; $display("FAIL hold frozen sel: got %b/%b want 101/000", sel_a, sel_b); end
        end
        hold = 1'b0;
        tick();
        checks++; if (sel_a !== 3'b001 || sel_b !== 3'b000) begin errors++; $display("FAIL hold release sel: got %b/%b want 001/000", sel_a, sel_b); end
        op_load(7, 2);
        tick();
        op_alu(8, 7, 1'b1, 7, 1'b1);
        hold = 1'b1;
        base = exp_cnt;
        repeat (3) begin
            tick();
            checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL hold ldu stall: got %b want 1", obs_stall); end
            checks++; if (stall_cnt !== 16'(base)) begin errors++; $display("FAIL hold cnt: got %0d want %0d", stall_cnt, base); end
            checks++; if (sel_a !== 3'b000 || sel_b !== 3'b100) begin errors++; $display("FAIL hold ldu sel: got %b/%b want 000/100", sel_a, sel_b); end
        end
        hold = 1'b0;
        tick();
        checks++; if (stall_cnt !== 16'(base + 1)) begin errors++; $display("FAIL hold release cnt: got %0d want %0d", stall_cnt, base + 1); end
        tick();
        checks++; if (sel_a !== 3'b010 || sel_b !== 3'b010) begin errors++; $display("FAIL hold release ldu sel: got %b/%b want 010/010", sel_a, sel_b); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            set_id($urandom_range(0, 9) < 8, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                   int'($urandom_range(0, 3)), $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 11) == 0);
            hold  = ($urandom_range(0, 9) == 0);
            tick();
            checks++; if (obs_stall !== exp_stall || obs_stall_s !== exp_stall) begin errors++; $display("FAIL rnd%0d stall: got %b/%b want %b", i, obs_stall, obs_stall_s, exp_stall); end
            checks++; if (sel_a !== exp_sel_a || sel_a_s !== exp_sel_a) begin errors++; $display("FAIL rnd%0d sel_a: got %b/%b want %b", i, sel_a, sel_a_s, exp_sel_a); end
            checks++; if (sel_b !== exp_sel_b || sel_b_s !== exp_sel_b) begin errors++; $display("FAIL rnd%0d sel_b: got %b/%b want %b", i, sel_b, sel_b_s, exp_sel_b); end
            checks++; if (stall_cnt !== 16'(sat(exp_cnt, 16))) begin errors++; $display("FAIL rnd%0d stall_cnt: got %0d want %0d", i, stall_cnt, sat(exp_cnt, 16)); end
            checks++; if (stall_cnt_s !== 4'(sat(exp_cnt, 4))) begin errors++; $display("FAIL rnd%0d stall_cnt_s: got %0d want %0d", i, stall_cnt_s, sat(exp_cnt, 4)); end
        end
        flush = 1'b0;
        hold  = 1'b0;
    endtask

    task automatic test_reset_mid();
        idle_cycles(2);
        op_load(7, 2);
        tick();
        op_alu(8, 7, 1'b1, 7, 1'b1);
        #2;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL prereset stall: got %b want 1", stall); end
        rst_n = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL async reset stall: got %b want 0", stall); end
        checks++; if (sel_a !== 3'b000 || sel_b !== 3'b000) begin errors++; $display("FAIL async reset sel: got %b/%b want 000/000", sel_a, sel_b); end
        checks++; if (stall_cnt !== 16'd0 || stall_cnt_s !== 4'd0) begin errors++; $display("FAIL async reset cnt: got %0d/%0d want 0/0", stall_cnt, stall_cnt_s); end
        m_reset();
        @(posedge clk);
        #1;
        checks++; if (sel_a !== 3'b000 || stall_cnt !== 16'd0) begin errors++; $display("FAIL in reset: sel_a %b cnt %0d want 000/0", sel_a, stall_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL stale stall after reset: got %b want 0", obs_stall); end
        checks++; if (sel_a !== 3'b000 || sel_b !== 3'b000) begin errors++; $display("FAIL stale fwd after reset: got %b/%b want 000/000", sel_a, sel_b); end
    endtask

    task automatic test_saturation();
        op_load(7, 7);
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++; if (stall_cnt_s !== 4'(sat(exp_cnt, 4))) begin errors++; $display("FAIL sat%0d small cnt: got %0d want %0d", i, stall_cnt_s, sat(exp_cnt, 4)); end
        end
        checks++; if (stall_cnt !== 16'd20) begin errors++; $display("FAIL sat wide cnt: got %0d want 20", stall_cnt); end
        checks++; if (stall_cnt_s !== 4'hF) begin errors++; $display("FAIL sat small cnt final: got %0d want 15", stall_cnt_s); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        m_reset();
        test_reset();
        test_ex_forward();
        test_load_use();
        test_x0_and_distance();
        test_flush();
        test_hold();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
